// File: rtl/password_enroll.sv
// rtl/password_enroll.sv - keypad password enrollment: two matching entries commit a new stored password.
module password_enroll #(
  parameter int             N           = 4,
  parameter logic [N-1:0]   DEFAULT_PWD = 4'b1010,
  parameter int             ERR_CYCLES  = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sw,
  input  logic [N-1:0] key,
  input  logic         enter,
  output logic [N-1:0] led,
  output logic [N-1:0] pwd_out,
  output logic         commit,
  output logic         busy,
  output logic         err
);

  localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ERR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER1 = 3'd1,
    ENTER2 = 3'd2,
    ERR    = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   buf_q, buf_d;
  logic [N-1:0]   first_q, first_d;
  logic [N-1:0]   pwd_q, pwd_d;
  logic           commit_q, commit_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   key_q;
  logic           enter_q;
  logic [N-1:0]   key_rise;
  logic           enter_rise;

  assign key_rise   = key & ~key_q;
  assign enter_rise = enter & ~enter_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    first_d  = first_q;
    pwd_d    = pwd_q;
    commit_d = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;

    // Dropping sw in any active entry state abandons the session outright.
    if (!sw && (state_q == ENTER1 || state_q == ENTER2 || state_q == ERR)) begin
      state_d = IDLE;
      buf_d   = '0;
      first_d = '0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sw) begin
            state_d = ENTER1;
            buf_d   = '0;
          end
        end
        ENTER1: begin
          if (enter_rise) begin
            first_d = buf_q;
            buf_d   = '0;
            state_d = ENTER2;
          end else begin
            buf_d = buf_q ^ key_rise;
          end
        end
        ENTER2: begin
          if (enter_rise) begin
            buf_d = '0;
            if (buf_q == first_q) begin
              pwd_d    = buf_q;
              commit_d = 1'b1;
              state_d  = HOLD;
            end else begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = ERR;
            end
          end else begin
            buf_d = buf_q ^ key_rise;
          end
        end
        ERR: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ENTER1;
            err_d   = 1'b0;
            cnt_d   = '0;
            first_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (!sw) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          buf_d   = '0;
          first_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      first_q  <= '0;
      pwd_q    <= DEFAULT_PWD;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      key_q    <= '0;
      enter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      first_q  <= first_d;
      pwd_q    <= pwd_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      key_q    <= key;
      enter_q  <= enter;
    end
  end

  assign led     = buf_q;
  assign pwd_out = pwd_q;
  assign commit  = commit_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_password_enroll.sv
// tb/tb_password_enroll.sv - directed self-checking bench for password_enroll.
module tb_password_enroll;

  logic       clk;
  logic       rst;
  logic       sw;
  logic [3:0] key;
  logic       enter;
  logic [3:0] led;
  logic [3:0] pwd_out;
  logic       commit;
  logic       busy;
  logic       err;

  int total;
  int bad;

  password_enroll #(
    .N          (4),
    .DEFAULT_PWD(4'b1010),
    .ERR_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .key    (key),
    .enter  (enter),
    .led    (led),
    .pwd_out(pwd_out),
    .commit (commit),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    sw    = 1'b0;
    key   = 4'b0000;
    enter = 1'b0;
    #3;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic press_keys(input logic [3:0] k);
    key = k;
    tick();
    key = 4'b0000;
    tick();
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    sw    = 1'b0;
    key   = 4'b0000;
    enter = 1'b0;
    #3;
    tick();
    total++;
    if (pwd_out !== 4'b1010 || led !== 4'b0000 || busy !== 1'b0 || err !== 1'b0 || commit !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: pwd=%b led=%b busy=%b err=%b commit=%b, want 1010 0000 0 0 0",
               pwd_out, led, busy, err, commit);
    end
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || pwd_out !== 4'b1010) begin
      bad++;
      $display("FAIL reset_idle: busy=%b pwd=%b, want 0 1010", busy, pwd_out);
    end
  endtask

  task automatic test_enroll();
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b0101);
    total++;
    if (led !== 4'b0101) begin
      bad++;
      $display("FAIL enroll_led1: got %b want 0101", led);
    end
    press_enter();
    total++;
    if (led !== 4'b0000) begin
      bad++;
      $display("FAIL enroll_led_clear: got %b want 0000", led);
    end
    press_keys(4'b0101);
    total++;
    if (led !== 4'b0101) begin
      bad++;
      $display("FAIL enroll_led2: got %b want 0101", led);
    end
    enter = 1'b1;
    tick();
    total++;
    if (commit !== 1'b1 || pwd_out !== 4'b0101 || busy !== 1'b1) begin
      bad++;
      $display("FAIL enroll_commit: commit=%b pwd=%b busy=%b, want 1 0101 1", commit, pwd_out, busy);
    end
    enter = 1'b0;
    tick();
    total++;
    if (commit !== 1'b0) begin
      bad++;
      $display("FAIL enroll_commit_width: commit=%b want 0", commit);
    end
    press_keys(4'b0011);
    press_enter();
    total++;
    if (busy !== 1'b1 || led !== 4'b0000 || commit !== 1'b0 || pwd_out !== 4'b0101) begin
      bad++;
      $display("FAIL enroll_hold: busy=%b led=%b commit=%b pwd=%b, want 1 0000 0 0101",
               busy, led, commit, pwd_out);
    end
    sw = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || pwd_out !== 4'b0101) begin
      bad++;
      $display("FAIL enroll_release: busy=%b pwd=%b, want 0 0101", busy, pwd_out);
    end
  endtask

  task automatic test_mismatch();
    int n;
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b0011);
    press_enter();
    press_keys(4'b0001);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n = 0;
    while (err === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL mismatch_err_len: got %0d cycles want 8", n);
    end
    total++;
    if (pwd_out !== 4'b1010 || led !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mismatch_return: pwd=%b led=%b busy=%b, want 1010 0000 1", pwd_out, led, busy);
    end
    press_keys(4'b1111);
    press_enter();
    press_keys(4'b1111);
    enter = 1'b1;
    tick();
    total++;
    if (commit !== 1'b1 || pwd_out !== 4'b1111) begin
      bad++;
      $display("FAIL mismatch_retry_commit: commit=%b pwd=%b, want 1 1111", commit, pwd_out);
    end
    enter = 1'b0;
    sw = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b0110);
    press_enter();
    press_keys(4'b0110);
    sw    = 1'b0;
    enter = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || commit !== 1'b0 || pwd_out !== 4'b1010 || led !== 4'b0000) begin
      bad++;
      $display("FAIL abort_idle: busy=%b commit=%b pwd=%b led=%b, want 0 0 1010 0000",
               busy, commit, pwd_out, led);
    end
    enter = 1'b0;
    tick();
    total++;
    if (commit !== 1'b0 || pwd_out !== 4'b1010) begin
      bad++;
      $display("FAIL abort_no_commit: commit=%b pwd=%b, want 0 1010", commit, pwd_out);
    end
  endtask

  task automatic test_err_abort();
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b0001);
    press_enter();
    press_keys(4'b0010);
    press_enter();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_abort_enter: err=%b want 1", err);
    end
    sw = 1'b0;
    tick();
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || pwd_out !== 4'b1010) begin
      bad++;
      $display("FAIL err_abort_idle: err=%b busy=%b pwd=%b, want 0 0 1010", err, busy, pwd_out);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b0010);
    total++;
    if (led !== 4'b0010) begin
      bad++;
      $display("FAIL toggle_set: led=%b want 0010", led);
    end
    press_keys(4'b0010);
    total++;
    if (led !== 4'b0000) begin
      bad++;
      $display("FAIL toggle_clear: led=%b want 0000", led);
    end
    key   = 4'b1000;
    enter = 1'b1;
    tick();
    total++;
    if (led !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL simul_discard: led=%b busy=%b, want 0000 1", led, busy);
    end
    key   = 4'b0000;
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    total++;
    if (commit !== 1'b1 || pwd_out !== 4'b0000) begin
      bad++;
      $display("FAIL simul_zero_commit: commit=%b pwd=%b, want 1 0000", commit, pwd_out);
    end
    enter = 1'b0;
    sw = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_session();
    do_reset();
    sw = 1'b1;
    tick();
    press_keys(4'b1001);
    press_enter();
    press_keys(4'b0100);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || pwd_out !== 4'b1010 || err !== 1'b0 || led !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid: busy=%b pwd=%b err=%b led=%b, want 0 1010 0 0000",
               busy, pwd_out, err, led);
    end
    sw = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_enroll();
    test_mismatch();
    test_abort();
    test_err_abort();
    test_simultaneous();
    test_reset_mid_session();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/password_enroll.md
Name: password_enroll

Overview:
- Enrollment (writer) side of the keypad password scheme: the user keys in a new N-bit password twice, and the block commits it only if both entries match.
- Holds the stored password that the checker compares against and presents it on pwd_out with a one-cycle commit strobe.
- Drives the board LEDs with the entry in progress.

Parameters:
- N, 4, password width = number of key inputs.
- DEFAULT_PWD, 4'b1010, value of pwd_out after reset (N bits).
- ERR_CYCLES, 25_000_000, duration of the mismatch error indication in clk cycles (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- sw  input  1  enroll enable; 1 = enrollment session active, 0 = abort/idle.
- key  input  N  debounced key levels, active-high; a rising edge on key[i] toggles bit i of the entry buffer.
- enter  input  1  debounced confirm key, active-high; a rising edge advances the session.
- led  output  N  current entry buffer.
- pwd_out  output  N  stored password.
- commit  output  1  one-cycle pulse when pwd_out is updated.
- busy  output  1  high in any state other than IDLE.
- err  output  1  high while in ERR.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; buf = 0; first = 0; led = 0.
  - pwd_out = DEFAULT_PWD; commit = 0; err = 0; busy = 0; error counter = 0.
  - Edge-detect history registers = 0.
- Edge detection:
  - key_q/enter_q hold the previous-cycle input values.
  - key_rise = key & ~key_q; enter_rise = enter & ~enter_q.
  - An input held high at reset release produces a rise in the first clock after release.
  - Effects appear in registers on the clock edge where the rise is seen, so led updates one cycle after the input rises.
- led = buf at all times (registered).
- FSM states: IDLE, ENTER1, ENTER2, ERR, HOLD.
  - IDLE:
    - busy=0; key and enter rises ignored.
    - sw=1 -> ENTER1, buf<=0.
  - ENTER1:
    - buf <= buf ^ key_rise.
    - enter_rise -> first<=buf, buf<=0, ENTER2.
  - ENTER2:
    - buf <= buf ^ key_rise.
    - enter_rise with buf==first -> pwd_out<=buf, commit<=1 for exactly one cycle, buf<=0, HOLD.
    - enter_rise with buf!=first -> ERR, err<=1, counter<=0, buf<=0.
  - ERR:
    - Counter increments each cycle; key and enter rises ignored.
    - When counter==ERR_CYCLES-1 -> ENTER1, err<=0, counter<=0, first<=0.
  - HOLD:
    - Waits for sw=0 so a session held high cannot re-enroll; all inputs ignored.
    - sw=0 -> IDLE.
- Abort: sw=0 in ENTER1, ENTER2 or ERR -> IDLE next cycle.
  - buf and first cleared; err cleared; pwd_out unchanged; no commit.
  - sw takes priority over enter_rise and counter expiry in the same cycle.
- Simultaneous key_rise and enter_rise in ENTER1/ENTER2:
  - enter acts on the old buf; that cycle's key toggles are discarded.
  - buf is cleared.
- Multiple key rises in one cycle toggle all corresponding bits.
- Entering an all-zero password twice is legal and commits 0.
- pwd_out changes only on a commit or on reset. commit is never asserted in two consecutive cycles.

Test Plan:
- Reset: hold rst=0, then release -> pwd_out=4'b1010, led=0, busy=0, err=0, commit=0.
- Successful enroll (ERR_CYCLES=8):
  - Stimulus: sw=1; pulse key[0] and key[2]; pulse enter; pulse key[0] and key[2]; pulse enter.
  - Required: led=4'b0101 before each enter; commit high exactly one cycle; pwd_out=4'b0101; state HOLD (busy=1) until sw=0, then busy=0.
- Mismatch:
  - Stimulus: enter 4'b0011, then 4'b0001.
  - Required: err=1 for exactly 8 cycles; pwd_out stays 4'b1010; return to ENTER1 with led=0; a following matching pair 4'b1111/4'b1111 commits 4'b1111.
- Abort:
  - Stimulus: after the first entry 4'b0110, drop sw during ENTER2 together with an enter rise.
  - Required: IDLE next cycle; no commit; pwd_out unchanged; led=0.
- Toggle/simultaneity: pulse key[1] twice, then key[3] and enter in the same cycle during ENTER1 -> first=4'b0000 (key[3] discarded), led=0.
- Reset mid-session: assert rst in ENTER2 after first=4'b1001 -> immediate IDLE, pwd_out=4'b1010, err=0, led=0.
